video_ram_arbiter: RTL and testbench

Shares the single system-RAM port between CPU memory cycles and video-fetch requests. System RAM is shared between the CPU and video, as on the PCjr.
- Sequences RAM accesses with a 4-state FSM.
- Gives video fixed priority, with a starvation guard for the CPU.
- Drives the chipset's VIDEO_READY input to the READY block, inserting CPU wait states while a CPU access is pending.

---
 rtl/chipset_pkg.sv | 16 +
 rtl/video_ram_arbiter_if.sv | 43 ++++
 rtl/video_ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_video_ram_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chipset_pkg.sv
// Shared chipset definitions: the RAM arbiter state type and default sizing
// of the system-RAM port, the access slot length and the video burst limit.
package chipset_pkg;

  localparam int RAM_ADDR_WIDTH    = 17;
  localparam int RAM_ACCESS_CYCLES = 2;
  localparam int VIDEO_MAX_BURST   = 4;

  typedef enum logic [1:0] {
    IDLE,
    VIDEO_ACCESS,
    CPU_ACCESS,
    CPU_HOLD
  } arbiter_state_t;

endpackage

// File: rtl/video_ram_arbiter_if.sv
// Bundle of the CPU, video-fetch and system-RAM signals around the arbiter.
// The slave modport is the arbiter side; master is everything around it.
interface video_ram_arbiter_if #(
  parameter int ADDR_WIDTH = chipset_pkg::RAM_ADDR_WIDTH
);

  logic                  cpu_request;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [7:0]            cpu_data_in;
  logic [7:0]            cpu_data_out;
  logic                  VIDEO_READY;

  logic                  video_request;
  logic [ADDR_WIDTH-1:0] video_address;
  logic [7:0]            video_data;
  logic                  video_ack;

  logic [ADDR_WIDTH-1:0] ram_address;
  logic [7:0]            ram_data_write;
  logic                  ram_read_enable;
  logic                  ram_write_enable;
  logic [7:0]            ram_data_read;

  modport slave (
    input  cpu_request, cpu_write, cpu_address, cpu_data_in,
    output cpu_data_out, VIDEO_READY,
    input  video_request, video_address,
    output video_data, video_ack,
    output ram_address, ram_data_write, ram_read_enable, ram_write_enable,
    input  ram_data_read
  );

  modport master (
    output cpu_request, cpu_write, cpu_address, cpu_data_in,
    input  cpu_data_out, VIDEO_READY,
    output video_request, video_address,
    input  video_data, video_ack,
    input  ram_address, ram_data_write, ram_read_enable, ram_write_enable,
    output ram_data_read
  );

endinterface

// File: rtl/video_ram_arbiter.sv
// Arbitrates the single system-RAM port between CPU cycles and video fetches.
// Video has fixed priority, bounded by a burst limit while the CPU is waiting.
module video_ram_arbiter
  import chipset_pkg::*;
#(
  parameter int ADDR_WIDTH      = RAM_ADDR_WIDTH,
  parameter int ACCESS_CYCLES   = RAM_ACCESS_CYCLES,
  parameter int MAX_VIDEO_BURST = VIDEO_MAX_BURST
) (
  input  logic                   clock,
  input  logic                   reset,
  video_ram_arbiter_if.slave     bus
);

  localparam int SLOT_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int BURST_W = $clog2(MAX_VIDEO_BURST + 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(ACCESS_CYCLES - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_VIDEO_BURST);

  arbiter_state_t        state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic                  cpu_served_q, cpu_served_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  re_q, re_d;
  logic                  we_q, we_d;
  logic [7:0]            cpu_data_q, cpu_data_d;
  logic [7:0]            video_data_q, video_data_d;
  logic                  ack_q, ack_d;
  logic                  ready_q, ready_d;

  logic cpu_pending;
  logic access_last;
  logic cpu_finishing;

  always_comb begin
    // NOTE: every next-state variable takes its current value first, so no path infers a latch.
    state_d      = state_q;
    slot_d       = slot_q;
    burst_d      = burst_q;
    cpu_served_d = cpu_served_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    re_d         = re_q;
    we_d         = we_q;
    cpu_data_d   = cpu_data_q;
    video_data_d = video_data_q;
    ack_d        = 1'b0;

    cpu_pending   = bus.cpu_request & ~cpu_served_q;
    access_last   = (slot_q == SLOT_LAST);
    cpu_finishing = (state_q == CPU_ACCESS) && access_last;

    // Wait states end on the very clock the CPU's data is captured.
    ready_d = ~(cpu_pending & ~cpu_finishing);

    // A held request stays served until the CPU lets go of it.
    if (cpu_finishing) begin
      cpu_served_d = 1'b1;
    end else if (!bus.cpu_request) begin
      cpu_served_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        slot_d = '0;
        if (bus.video_request && ((burst_q < BURST_MAX) || !cpu_pending)) begin
          state_d = VIDEO_ACCESS;
          addr_d  = bus.video_address;
          re_d    = 1'b1;
          we_d    = 1'b0;
          if (burst_q != BURST_MAX) begin
            burst_d = burst_q + BURST_W'(1);
          end
        end else if (cpu_pending) begin
          state_d = CPU_ACCESS;
          addr_d  = bus.cpu_address;
          wdata_d = bus.cpu_data_in;
          re_d    = ~bus.cpu_write;
          we_d    = bus.cpu_write;
          burst_d = '0;
        end else begin
          burst_d = '0;
        end
      end

      VIDEO_ACCESS: begin
        if (access_last) begin
          state_d      = IDLE;
          re_d         = 1'b0;
          video_data_d = bus.ram_data_read;
          ack_d        = 1'b1;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end

      CPU_ACCESS: begin
        if (access_last) begin
          state_d = CPU_HOLD;
          if (re_q) begin
            cpu_data_d = bus.ram_data_read;
          end
          re_d = 1'b0;
          we_d = 1'b0;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end

      CPU_HOLD: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: data registers are reset too; a dropped access must leave no stale data visible.
      state_q      <= IDLE;
      slot_q       <= '0;
      burst_q      <= '0;
      cpu_served_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      cpu_data_q   <= '0;
      video_data_q <= '0;
      ack_q        <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      burst_q      <= burst_d;
      cpu_served_q <= cpu_served_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      re_q         <= re_d;
      we_q         <= we_d;
      cpu_data_q   <= cpu_data_d;
      video_data_q <= video_data_d;
      ack_q        <= ack_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.ram_address      = addr_q;
  assign bus.ram_data_write   = wdata_q;
  assign bus.ram_read_enable  = re_q;
  assign bus.ram_write_enable = we_q;
  assign bus.cpu_data_out     = cpu_data_q;
  assign bus.video_data       = video_data_q;
  assign bus.video_ack        = ack_q;
  assign bus.VIDEO_READY      = ready_q;

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Bench for video_ram_arbiter: a timeline model of RAM occupancy checked every
// clock, plus directed scenarios with hand-computed literal expectations.
module tb_video_ram_arbiter;

  localparam int AW = 17;
  localparam int AC = 2;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  video_ram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  video_ram_arbiter #(
    .ADDR_WIDTH     (AW),
    .ACCESS_CYCLES  (AC),
    .MAX_VIDEO_BURST(MB)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  // Behavioural RAM seen by the DUT, and an independent reference copy.
  logic [7:0] mem     [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  assign bus.ram_data_read = bus.ram_read_enable ? mem[bus.ram_address] : 8'h00;

  always @(posedge clk) begin
    if (bus.ram_write_enable) mem[bus.ram_address] <= bus.ram_data_write;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the port is a timeline. A grant at edge g owns the RAM for edges
  // g..g+AC-1, completes at g+AC, and frees arbitration at g+AC+1 (video) or
  // g+AC+2 (CPU, which adds its hold clock).
  int unsigned     edge_n, free_at, acc_start, burst;
  bit              acc_active, acc_video, acc_write, served;
  logic [AW-1:0]   acc_addr;
  logic [7:0]      acc_wdata;
  logic            exp_re, exp_we, exp_ack, exp_ready;
  logic [7:0]      exp_vdata, exp_cdata;

  task automatic model_step();
    bit pending, at_end, finishing;
    if (rst) begin
      edge_n = 0; free_at = 0; acc_start = 0; burst = 0;
      acc_active = 0; acc_video = 0; acc_write = 0; served = 0;
      acc_addr = '0; acc_wdata = '0;
      exp_re = 0; exp_we = 0; exp_ack = 0; exp_ready = 1;
      exp_vdata = '0; exp_cdata = '0;
      return;
    end
    edge_n++;
    pending   = bus.cpu_request && !served;
    at_end    = acc_active && (edge_n == acc_start + AC);
    finishing = at_end && !acc_video;
    exp_ack   = 0;
    exp_ready = !(pending && !finishing);
    if (at_end) begin
      if (acc_video) begin
        exp_vdata = ref_mem[acc_addr];
        exp_ack   = 1;
      end else if (!acc_write) begin
        exp_cdata = ref_mem[acc_addr];
      end
      acc_active = 0;
    end
    if (finishing) served = 1;
    else if (!bus.cpu_request) served = 0;
    if (edge_n >= free_at) begin
      if (bus.video_request && (burst < MB || !pending)) begin
        acc_active = 1; acc_video = 1; acc_write = 0;
        acc_start = edge_n; acc_addr = bus.video_address;
        free_at = edge_n + AC + 1;
        if (burst < MB) burst++;
      end else if (pending) begin
        acc_active = 1; acc_video = 0; acc_write = bus.cpu_write;
        acc_start = edge_n; acc_addr = bus.cpu_address; acc_wdata = bus.cpu_data_in;
        free_at = edge_n + AC + 2;
        burst = 0;
        if (acc_write) ref_mem[acc_addr] = acc_wdata;
      end else begin
        burst = 0;
      end
    end
    exp_re = acc_active && !acc_write;
    exp_we = acc_active && acc_write;
  endtask

  initial begin
    exp_re = 0; exp_we = 0; exp_ack = 0; exp_ready = 1;
    exp_vdata = '0; exp_cdata = '0;
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("ram_read_enable",  32'(bus.ram_read_enable),  32'(exp_re));
      check("ram_write_enable", 32'(bus.ram_write_enable), 32'(exp_we));
      check("video_ack",        32'(bus.video_ack),        32'(exp_ack));
      check("VIDEO_READY",      32'(bus.VIDEO_READY),      32'(exp_ready));
      check("video_data",       32'(bus.video_data),       32'(exp_vdata));
      check("cpu_data_out",     32'(bus.cpu_data_out),     32'(exp_cdata));
      if (exp_re || exp_we) check("ram_address", 32'(bus.ram_address), 32'(acc_addr));
      if (exp_we) check("ram_data_write", 32'(bus.ram_data_write), 32'(acc_wdata));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.video_ack) seen = 1;
    end
    if (!seen) check({name, " ack timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_ready(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.VIDEO_READY) seen = 1;
    end
    if (!seen) check({name, " ready timeout"}, 32'(seen), 32'd1);
  endtask

  int re_cnt, we_cnt, acks, low;
  bit done;

  initial begin
    bus.cpu_request = 0; bus.cpu_write = 0; bus.cpu_address = '0; bus.cpu_data_in = '0;
    bus.video_request = 0; bus.video_address = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = pat(AW'(i));
      ref_mem[i] = pat(AW'(i));
    end
    mem[17'h01234]     = 8'hA5;
    ref_mem[17'h01234] = 8'hA5;

    // 1: reset with both requests held; first grant after release is video.
    bus.cpu_request = 1; bus.cpu_address = 17'h00020;
    bus.video_request = 1; bus.video_address = 17'h00100;
    #1 rst = 1;
    tick(3);
    check("t1 reset VIDEO_READY", 32'(bus.VIDEO_READY), 32'd1);
    check("t1 reset read strobe", 32'(bus.ram_read_enable), 32'd0);
    check("t1 reset write strobe", 32'(bus.ram_write_enable), 32'd0);
    check("t1 reset ack", 32'(bus.video_ack), 32'd0);
    check("t1 reset address", 32'(bus.ram_address), 32'd0);
    rst = 0;
    tick(1);
    check("t1 first grant is video", 32'(bus.ram_read_enable), 32'd1);
    check("t1 first grant address", 32'(bus.ram_address), 32'h00100);
    wait_ack("t1", 8);
    check("t1 video data", 32'(bus.video_data), 32'h5D);
    bus.video_request = 0;
    wait_ready("t1", 10);
    check("t1 cpu read data", 32'(bus.cpu_data_out), 32'h7C);
    bus.cpu_request = 0;
    tick(3);

    // 2: CPU read, video idle.
    bus.cpu_address = 17'h01234; bus.cpu_write = 0; bus.cpu_request = 1;
    re_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.ram_read_enable) re_cnt++;
      if (k == 3) begin
        check("t2 cpu_data_out at +3", 32'(bus.cpu_data_out), 32'hA5);
        check("t2 VIDEO_READY at +3", 32'(bus.VIDEO_READY), 32'd1);
      end
    end
    check("t2 read strobe clocks", 32'(re_cnt), 32'd2);
    bus.cpu_request = 0;
    tick(3);

    // 3: CPU write, then drop and re-raise for exactly one more write.
    bus.cpu_address = 17'h00010; bus.cpu_write = 1; bus.cpu_data_in = 8'h3C; bus.cpu_request = 1;
    for (int phase = 0; phase < 2; phase++) begin
      re_cnt = 0; we_cnt = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (bus.ram_write_enable) we_cnt++;
        if (bus.ram_read_enable) re_cnt++;
      end
      check("t3 write strobe clocks", 32'(we_cnt), 32'd2);
      check("t3 no read strobe", 32'(re_cnt), 32'd0);
      bus.cpu_request = 0;
      tick(2);
      bus.cpu_request = (phase == 0);
    end
    tick(2);
    bus.cpu_write = 0; bus.cpu_request = 1;
    wait_ready("t3 readback", 10);
    check("t3 readback data", 32'(bus.cpu_data_out), 32'h3C);
    bus.cpu_request = 0;
    tick(3);

    // 4: simultaneous requests, burst count zero: video first.
    bus.video_address = 17'h00200; bus.video_request = 1;
    bus.cpu_address = 17'h01234; bus.cpu_write = 0; bus.cpu_request = 1;
    tick(1);
    check("t4 video granted first", 32'(bus.ram_address), 32'h00200);
    wait_ack("t4", 8);
    check("t4 video data", 32'(bus.video_data), 32'h5E);
    bus.video_request = 0;
    wait_ready("t4", 10);
    check("t4 cpu read data", 32'(bus.cpu_data_out), 32'hA5);
    bus.cpu_request = 0;
    tick(3);

    // 5: continuous video against a pending CPU read: four acks, then CPU.
    bus.video_address = 17'h00300; bus.video_request = 1;
    bus.cpu_address = 17'h00040; bus.cpu_write = 0; bus.cpu_request = 1;
    acks = 0; low = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.video_ack) acks++;
      if (!bus.VIDEO_READY) low++;
      else if (low > 0) done = 1;
    end
    check("t5 cpu completed", 32'(done), 32'd1);
    check("t5 video acks before cpu", 32'(acks), 32'd4);
    check("t5 ready low <= 15", 32'(low <= 15), 32'd1);
    check("t5 cpu read data", 32'(bus.cpu_data_out), 32'h1C);
    bus.video_request = 0; bus.cpu_request = 0;
    tick(4);

    // 6: reset lands on the first clock of a CPU access.
    bus.cpu_address = 17'h01234; bus.cpu_write = 0; bus.cpu_request = 1;
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("t6 read strobe falls async", 32'(bus.ram_read_enable), 32'd0);
    check("t6 write strobe", 32'(bus.ram_write_enable), 32'd0);
    check("t6 VIDEO_READY", 32'(bus.VIDEO_READY), 32'd1);
    check("t6 no ack", 32'(bus.video_ack), 32'd0);
    check("t6 cpu_data_out cleared", 32'(bus.cpu_data_out), 32'd0);
    tick(2);
    rst = 0;
    tick(1);
    check("t6 regrant after reset", 32'(bus.ram_read_enable), 32'd1);
    wait_ready("t6", 10);
    check("t6 cpu read data", 32'(bus.cpu_data_out), 32'hA5);
    bus.cpu_request = 0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
